mux4_rr_sel: RTL and testbench
==============================

MUX4_RR_SEL -- requirements
Module: mux4_rr_sel

Interface
REQ-001 SHALL have parameter DWELL, default 4, meaning number of enabled cycles a granted channel holds sel (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have port en  input  1  advance enable; when low, the dwell count pauses.
REQ-005 SHALL have port req  input  4  per-channel request; req[i] maps to mux input in(i+1).
REQ-006 SHALL have port sel  output  2  registered select driving the downstream 4:1 mux sel.
REQ-007 SHALL have port sel_valid  output  1  high while a channel is granted and sel is meaningful.
REQ-008 SHALL have port grant  output  4  registered one-hot of the granted channel; all zero when idle.
REQ-009 SHALL have port switched  output  1  one-cycle pulse in the cycle sel takes a new granted value.

Function
REQ-010 SHALL implement two states: IDLE (no grant) and HOLD (one channel granted).
REQ-011 SHALL keep an internal 2-bit last-granted pointer ptr and an 8-bit dwell counter cnt.
REQ-012 SHALL, in IDLE with en=1 and req!=0, grant the first requesting channel in the order ptr+1, ptr+2, ptr+3, ptr (mod 4), load cnt=DWELL-1, and enter HOLD on that edge.
REQ-013 SHALL, in IDLE with en=0 or req=0, remain in IDLE with sel unchanged, sel_valid=0 and grant=0.
REQ-014 SHALL, in HOLD with en=1, cnt!=0 and req[sel]=1, decrement cnt and keep sel and grant unchanged.
REQ-015 SHALL, in HOLD with en=0, hold cnt, sel and grant unchanged, even if req[sel] drops.
REQ-016 SHALL, in HOLD with en=1 and either cnt=0 or req[sel]=0, perform re-arbitration with the REQ-012 search order, using ptr=sel.
REQ-017 SHALL, on re-arbitration, switch directly to the winner with no idle bubble and reload cnt=DWELL-1.
REQ-018 SHALL, on re-arbitration where req=0, enter IDLE with sel_valid=0 and grant=0, and hold sel at its last value.
REQ-019 SHALL, on re-arbitration where the only requester is the current channel, re-grant it with cnt reloaded and no switched pulse.
REQ-020 SHALL update ptr to the granted channel on every grant.
REQ-021 SHALL assert switched for exactly one cycle when sel_valid rises, or when sel changes while sel_valid stays high.
REQ-022 SHALL, with DWELL=1, allow a new arbitration every enabled cycle.
REQ-023 SHALL keep grant equal to one-hot(sel) whenever sel_valid=1, and SHALL have no combinational path from req or en to any output.

Reset
REQ-024 SHALL, while rst=1, asynchronously force state=IDLE, sel=0, sel_valid=0, grant=0, switched=0, cnt=0 and ptr=3, so that the first search starts at channel 0.
REQ-025 SHALL, on rst asserted mid-HOLD, drop the grant immediately without waiting for a clock edge.
REQ-026 SHALL, on the first edge after rst deasserts, resume normal operation per REQ-012.

Verification
REQ-027 SHALL verify reset: with req=4'b1111 and en=1 applied during rst, outputs stay sel=0, grant=0, sel_valid=0; on the first edge after release, grant=4'b0001, sel=0 and switched pulses.
REQ-028 SHALL verify rotation: with DWELL=4, req=4'b1111 and en=1, sel steps 0,1,2,3,0, each value held 4 cycles, with switched pulsing once per step.
REQ-029 SHALL verify early drop: with channel 1 granted, dropping req[1] in cycle 2 of its dwell while req=4'b1100 gives sel=2 on the next edge.
REQ-030 SHALL verify pause: holding en=0 for 5 cycles mid-dwell leaves sel, grant and cnt unchanged; the dwell completes after en returns to 1.
REQ-031 SHALL verify single requester: with req=4'b1000 held, sel=3 stays continuously valid, switched pulses only once and there is no IDLE gap.
REQ-032 SHALL verify idle return: with req dropping to 0 at dwell end, sel_valid=0 and grant=0 on the next edge, sel holds its last value, and a later req=4'b0001 is granted on the next edge.

Source files
------------

// File: rtl/mux4_rr_sel.sv
// Round-robin select generator for a downstream 4:1 mux. A granted channel keeps
// sel for DWELL enabled cycles, or until it drops its request, then the next
// requester after it (in rotating order) takes over without an idle bubble.
// All outputs are registered; nothing from req/en reaches an output combinationally.

module mux4_rr_sel #(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [1:0] sel,
    output logic       sel_valid,
    output logic [3:0] grant,
    output logic       switched
);

    typedef enum logic [0:0] {
        StIdle,
        StHold
    } state_e;

    // Dwell counter counts down to zero, so the reload is one less than the hold length.
    localparam logic [7:0] CntReload = 8'(DWELL - 1);

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] sel_q, sel_d;
    logic       sel_valid_q, sel_valid_d;
    logic [3:0] grant_q, grant_d;
    logic       switched_q, switched_d;

    logic [1:0] search_base;
    logic [1:0] winner;
    logic       any_req;
    logic       hold_expire;
    logic       take_grant;
    logic       go_idle;

    // Search origin: the current channel while holding, else the last-granted pointer.
    always_comb begin
        search_base = (state_q == StHold) ? sel_q : ptr_q;
    end

    // Rotating priority search: base+1, base+2, base+3, then base itself.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        winner = search_base;
        found  = 1'b0;
        idx    = search_base;
        for (int unsigned i = 1; i <= 4; i++) begin
            idx = search_base + 2'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Arbitration decision terms shared by next-state and datapath logic.
    always_comb begin
        any_req     = |req;
        hold_expire = (cnt_q == 8'd0) || !req[sel_q];
        take_grant  = en && any_req && ((state_q == StIdle) || hold_expire);
        go_idle     = (state_q == StHold) && en && hold_expire && !any_req;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (en && any_req) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (go_idle) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of pointer, counter and the registered outputs.
    always_comb begin
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        sel_valid_d = sel_valid_q;
        grant_d     = grant_q;
        switched_d  = 1'b0;
        if (take_grant) begin
            ptr_d       = winner;
            cnt_d       = CntReload;
            sel_d       = winner;
            sel_valid_d = 1'b1;
            grant_d     = 4'b0001 << winner;
            // A re-grant of the same channel while valid is not a switch.
            switched_d  = !sel_valid_q || (winner != sel_q);
        end else if ((state_q == StHold) && en && !hold_expire) begin
            cnt_d = cnt_q - 8'd1;
        end else if (go_idle) begin
            // sel keeps its last value so the mux input stays stable while idle.
            sel_valid_d = 1'b0;
            grant_d     = 4'b0000;
        end
    end

    // Datapath and output registers; reset points ptr at 3 so the first search starts at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= 2'd3;
            cnt_q       <= 8'd0;
            sel_q       <= 2'd0;
            sel_valid_q <= 1'b0;
            grant_q     <= 4'b0000;
            switched_q  <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            grant_q     <= grant_d;
            switched_q  <= switched_d;
        end
    end

    // Output drive straight from registers.
    always_comb begin
        sel       = sel_q;
        sel_valid = sel_valid_q;
        grant     = grant_q;
        switched  = switched_q;
    end

endmodule

// File: tb/tb_mux4_rr_sel.sv
// Self-checking bench: two instances (DWELL=4 and DWELL=1) driven by the same
// stimulus, each compared every cycle against a behavioural round-robin model.

module tb_mux4_rr_sel;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] req;

    logic [1:0] sel_a, sel_b;
    logic       valid_a, valid_b;
    logic [3:0] grant_a, grant_b;
    logic       sw_a, sw_b;

    int n_checks;
    int n_errors;

    // Model state per instance: 0 -> DWELL=4, 1 -> DWELL=1.
    int m_dwell [2];
    bit m_hold  [2];
    int m_sel   [2];
    int m_ptr   [2];
    int m_cnt   [2];
    bit m_sw    [2];

    mux4_rr_sel #(.DWELL(4)) dut_a (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .sel(sel_a), .sel_valid(valid_a), .grant(grant_a), .switched(sw_a)
    );

    mux4_rr_sel #(.DWELL(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .sel(sel_b), .sel_valid(valid_b), .grant(grant_b), .switched(sw_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int first_after(input int base, input logic [3:0] r);
        for (int i = 1; i <= 4; i++) begin
            if (r[(base + i) % 4]) return (base + i) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_hold[k] = 0;
            m_sel[k]  = 0;
            m_ptr[k]  = 3;
            m_cnt[k]  = 0;
            m_sw[k]   = 0;
        end
    endtask

    // One rising edge of the reference behaviour.
    task automatic model_step(input logic e, input logic [3:0] r);
        int w;
        for (int k = 0; k < 2; k++) begin
            m_sw[k] = 0;
            if (!e) continue;
            if (m_hold[k] && m_cnt[k] > 0 && r[m_sel[k]]) begin
                m_cnt[k] = m_cnt[k] - 1;
                continue;
            end
            w = first_after(m_hold[k] ? m_sel[k] : m_ptr[k], r);
            if (w < 0) begin
                m_hold[k] = 0;
            end else begin
                m_sw[k]   = !m_hold[k] || (w != m_sel[k]);
                m_hold[k] = 1;
                m_sel[k]  = w;
                m_ptr[k]  = w;
                m_cnt[k]  = m_dwell[k] - 1;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("a_sel", 32'(sel_a), 32'(m_sel[0]));
        check_eq("a_valid", 32'(valid_a), 32'(m_hold[0]));
        check_eq("a_grant", 32'(grant_a), m_hold[0] ? (32'd1 << m_sel[0]) : 32'd0);
        check_eq("a_switched", 32'(sw_a), 32'(m_sw[0]));
        check_eq("b_sel", 32'(sel_b), 32'(m_sel[1]));
        check_eq("b_valid", 32'(valid_b), 32'(m_hold[1]));
        check_eq("b_grant", 32'(grant_b), m_hold[1] ? (32'd1 << m_sel[1]) : 32'd0);
        check_eq("b_switched", 32'(sw_b), 32'(m_sw[1]));
    endtask

    // Called at posedge+1; drives inputs, takes one edge, checks at posedge+1.
    task automatic cycle(input logic e, input logic [3:0] r);
        en  = e;
        req = r;
        @(posedge clk);
        model_step(e, r);
        #1;
        compare_all();
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_a_sel"}, 32'(sel_a), 32'd0);
        check_eq({tag, "_a_grant"}, 32'(grant_a), 32'd0);
        check_eq({tag, "_a_valid"}, 32'(valid_a), 32'd0);
        check_eq({tag, "_a_sw"}, 32'(sw_a), 32'd0);
        check_eq({tag, "_b_grant"}, 32'(grant_b), 32'd0);
        check_eq({tag, "_b_valid"}, 32'(valid_b), 32'd0);
    endtask

    // Reset held across one edge with the given inputs applied; ends at posedge+1.
    task automatic do_reset(input logic e, input logic [3:0] r);
        en  = e;
        req = r;
        rst = 1'b1;
        #1;
        check_idle_outputs("rst_async");
        @(posedge clk);
        #1;
        check_idle_outputs("rst_edge");
        rst = 1'b0;
        model_reset();
    endtask

    int sw_count;
    bit gap_seen;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        m_dwell[0] = 4;
        m_dwell[1] = 1;
        model_reset();
        rst = 1'b1;
        en  = 1'b0;
        req = 4'b0000;
        @(posedge clk);
        #1;

        // Reset with all requests pending, then rotation 0,1,2,3,0.
        do_reset(1'b1, 4'b1111);
        cycle(1'b1, 4'b1111);
        check_eq("first_grant", 32'(grant_a), 32'b0001);
        check_eq("first_switched", 32'(sw_a), 32'd1);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 4'b1111);
            check_eq("rotation_sel", 32'(sel_a), 32'((i + 1) / 4 % 4));
        end

        // Early drop: channel 1 loses its request in cycle 2 of its dwell.
        do_reset(1'b0, 4'b0000);
        cycle(1'b1, 4'b0010);
        cycle(1'b1, 4'b0010);
        cycle(1'b1, 4'b1100);
        check_eq("early_drop_sel", 32'(sel_a), 32'd2);

        // Pause mid-dwell, including a request drop while paused.
        do_reset(1'b0, 4'b0000);
        cycle(1'b1, 4'b1111);
        cycle(1'b1, 4'b1111);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, (i == 2) ? 4'b1110 : 4'b1111);
            check_eq("pause_sel", 32'(sel_a), 32'd0);
            check_eq("pause_grant", 32'(grant_a), 32'b0001);
        end
        cycle(1'b1, 4'b1111);
        cycle(1'b1, 4'b1111);
        check_eq("pause_resume_sel", 32'(sel_a), 32'd0);
        cycle(1'b1, 4'b1111);
        check_eq("pause_done_sel", 32'(sel_a), 32'd1);

        // Single requester: continuous grant of channel 3, one switched pulse.
        do_reset(1'b0, 4'b0000);
        sw_count = 0;
        gap_seen = 0;
        for (int i = 0; i < 14; i++) begin
            cycle(1'b1, 4'b1000);
            sw_count += int'(sw_a);
            if (!valid_a || sel_a != 2'd3) gap_seen = 1;
        end
        check_eq("single_sw_count", 32'(sw_count), 32'd1);
        check_eq("single_no_gap", 32'(gap_seen), 32'd0);

        // Idle return at dwell end, then a fresh request.
        do_reset(1'b0, 4'b0000);
        cycle(1'b1, 4'b0100);
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'b0100);
        cycle(1'b1, 4'b0000);
        check_eq("idle_valid", 32'(valid_a), 32'd0);
        check_eq("idle_grant", 32'(grant_a), 32'd0);
        check_eq("idle_sel_hold", 32'(sel_a), 32'd2);
        cycle(1'b1, 4'b0000);
        cycle(1'b1, 4'b0001);
        check_eq("idle_regrant", 32'(grant_a), 32'b0001);

        // Asynchronous reset mid-hold drops the grant before the next edge.
        cycle(1'b1, 4'b1111);
        #3;
        rst = 1'b1;
        #1;
        check_eq("async_rst_grant", 32'(grant_a), 32'd0);
        check_eq("async_rst_valid", 32'(valid_a), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Randomized traffic with occasional pauses and resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset(1'b0, 4'(($urandom)));
            end else begin
                cycle(($urandom_range(0, 4) != 0), 4'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound so the run cannot hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
